idecode_fwd: RTL and testbench

//  Parametrised bexkat1 decode stage: selects source regs by ir_type, reads an internal

---
 rtl/idecode_fwd.sv | 142 ++++++++++++++
 tb/tb_idecode_fwd.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/idecode_fwd.sv
// bexkat1 decode stage: source select, register file, lane-wise EX/WB forwarding,
// load-use hazard detection and the ID/EX pipeline register.
module idecode_fwd #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int IR_W   = 64,
  parameter int WEN_W  = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IR_W-1:0]   ir_i,
  input  logic [31:0]       pc_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [WEN_W-1:0]  wb_wen_i,
  input  logic [AW-1:0]     wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [WEN_W-1:0]  ex_wen_i,
  input  logic [AW-1:0]     ex_addr_i,
  input  logic [DATA_W-1:0] ex_data_i,
  output logic              stall_o,
  output logic [IR_W-1:0]   ir_o,
  output logic [31:0]       pc_o,
  output logic [WEN_W-1:0]  reg_write_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o
);

  localparam int LW = DATA_W / WEN_W;

  localparam logic [3:0] T_CMP   = 4'h3;
  localparam logic [3:0] T_MOV   = 4'h4;
  localparam logic [3:0] T_ALU   = 4'h6;
  localparam logic [3:0] T_LDI   = 4'ha;
  localparam logic [3:0] T_LOAD  = 4'hb;
  localparam logic [3:0] T_STORE = 4'hc;

  logic [DATA_W-1:0] regs [NREGS];

  logic [IR_W-1:0]   ir_p1;
  logic [31:0]       pc_p1;
  logic [WEN_W-1:0]  rw_p1;
  logic [DATA_W-1:0] d1_p1;
  logic [DATA_W-1:0] d2_p1;

  logic [3:0]        ir_type_p0;
  logic [AW-1:0]     src1_p0;
  logic [AW-1:0]     src2_p0;
  logic [WEN_W-1:0]  rw_p0;
  logic [DATA_W-1:0] d1_p0;
  logic [DATA_W-1:0] d2_p0;

  // Each lane independently picks EX, then WB write-through, then the stored value.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [AW-1:0]     src,
    input logic [DATA_W-1:0] rf,
    input logic [WEN_W-1:0]  ex_wen,
    input logic [AW-1:0]     ex_addr,
    input logic [DATA_W-1:0] ex_data,
    input logic [WEN_W-1:0]  wb_wen,
    input logic [AW-1:0]     wb_addr,
    input logic [DATA_W-1:0] wb_data
  );
    logic [DATA_W-1:0] res;
    res = rf;
    for (int k = 0; k < WEN_W; k++) begin
      if (ex_wen[k] && ex_addr == src)
        res[k*LW +: LW] = ex_data[k*LW +: LW];
      else if (wb_wen[k] && wb_addr == src)
        res[k*LW +: LW] = wb_data[k*LW +: LW];
    end
    return res;
  endfunction

  // Stage p0: decode and operand fetch
  always_comb begin
    ir_type_p0 = ir_i[31:28];
    if (ir_type_p0 == T_CMP || ir_type_p0 == T_STORE || ir_type_p0 == T_LOAD) begin
      src1_p0 = ir_i[20 +: AW];
      src2_p0 = ir_i[16 +: AW];
    end else begin
      src1_p0 = ir_i[16 +: AW];
      src2_p0 = ir_i[12 +: AW];
    end
    if (ir_type_p0 == T_LDI || ir_type_p0 == T_LOAD || ir_type_p0 == T_ALU)
      rw_p0 = '1;
    else if (ir_type_p0 == T_MOV)
      rw_p0 = ir_i[24 +: WEN_W];
    else
      rw_p0 = '0;
    d1_p0 = fwd(src1_p0, regs[src1_p0], ex_wen_i, ex_addr_i, ex_data_i,
                wb_wen_i, wb_addr_i, wb_data_i);
    d2_p0 = fwd(src2_p0, regs[src2_p0], ex_wen_i, ex_addr_i, ex_data_i,
                wb_wen_i, wb_addr_i, wb_data_i);
  end

  // A load still in ID/EX cannot supply its result yet; the dependent instruction waits.
  always_comb begin
    stall_o = !flush_i && ir_p1[31:28] == T_LOAD && rw_p1 != '0 &&
              (ir_p1[20 +: AW] == src1_p0 || ir_p1[20 +: AW] == src2_p0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int k = 0; k < WEN_W; k++)
        if (wb_wen_i[k]) regs[wb_addr_i][k*LW +: LW] <= wb_data_i[k*LW +: LW];
    end
  end

  // Stage p1: ID/EX register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ir_p1 <= '0;
      pc_p1 <= '0;
      rw_p1 <= '0;
      d1_p1 <= '0;
      d2_p1 <= '0;
    end else if (flush_i || (!stall_i && stall_o)) begin
      ir_p1 <= '0;
      pc_p1 <= pc_i;
      rw_p1 <= '0;
      d1_p1 <= '0;
      d2_p1 <= '0;
    end else if (!stall_i) begin
      ir_p1 <= ir_i;
      pc_p1 <= pc_i;
      rw_p1 <= rw_p0;
      d1_p1 <= d1_p0;
      d2_p1 <= d2_p0;
    end
  end

  assign ir_o        = ir_p1;
  assign pc_o        = pc_p1;
  assign reg_write_o = rw_p1;
  assign data1_o     = d1_p1;
  assign data2_o     = d2_p1;

endmodule

// File: tb/tb_idecode_fwd.sv
// Directed bench for idecode_fwd: forwarding, write-through, hazards, stall and flush.
module tb_idecode_fwd;

  localparam logic [3:0] T_CMP   = 4'h3;
  localparam logic [3:0] T_MOV   = 4'h4;
  localparam logic [3:0] T_ALU   = 4'h6;
  localparam logic [3:0] T_LDI   = 4'ha;
  localparam logic [3:0] T_LOAD  = 4'hb;
  localparam logic [3:0] T_STORE = 4'hc;

  logic        clk = 0;
  logic        rst;
  logic [63:0] ir_i;
  logic [31:0] pc_i;
  logic        stall_i, flush_i;
  logic [1:0]  wb_wen, ex_wen;
  logic [3:0]  wb_addr, ex_addr;
  logic [31:0] wb_data, ex_data;
  logic        stall_o;
  logic [63:0] ir_o;
  logic [31:0] pc_o;
  logic [1:0]  reg_write_o;
  logic [31:0] data1_o, data2_o;

  int nvec = 0;
  int nerr = 0;

  idecode_fwd dut (
    .clk_i(clk), .rst_i(rst), .ir_i(ir_i), .pc_i(pc_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .wb_wen_i(wb_wen), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .ex_wen_i(ex_wen), .ex_addr_i(ex_addr), .ex_data_i(ex_data),
    .stall_o(stall_o), .ir_o(ir_o), .pc_o(pc_o), .reg_write_o(reg_write_o),
    .data1_o(data1_o), .data2_o(data2_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic [3:0] t, op, ra, rb, rc);
    logic [63:0] w;
    w = 64'h0000_00a5_0000_0000;
    w[31:28] = t; w[27:24] = op; w[23:20] = ra; w[19:16] = rb; w[15:12] = rc;
    w[11:0] = 12'h5a5;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
    wb_wen = 2'b11; wb_addr = a; wb_data = d;
    tick();
    wb_wen = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1; ir_i = mk(T_LOAD, 0, 1, 1, 1); pc_i = 32'h44;
    stall_i = 0; flush_i = 0; wb_wen = 0; wb_addr = 0; wb_data = 0;
    ex_wen = 0; ex_addr = 0; ex_data = 0;
    tick(); tick();
    nvec++; if (ir_o !== 64'h0) begin nerr++; $display("FAIL reset_ir got %h want 0", ir_o); end
    nvec++; if (pc_o !== 32'h0) begin nerr++; $display("FAIL reset_pc got %h want 0", pc_o); end
    nvec++; if (reg_write_o !== 2'b00) begin nerr++; $display("FAIL reset_rw got %b want 00", reg_write_o); end
    nvec++; if (data1_o !== 32'h0 || data2_o !== 32'h0) begin nerr++; $display("FAIL reset_data got %h %h want 0 0", data1_o, data2_o); end
    nvec++; if (stall_o !== 1'b0) begin nerr++; $display("FAIL reset_stall got %b want 0", stall_o); end
    rst = 0; ir_i = 64'h0; pc_i = 0;
  endtask

  task automatic test_alu();
    logic [63:0] w;
    wb_write(4'd2, 32'd5);
    wb_write(4'd3, 32'd7);
    w = mk(T_ALU, 0, 1, 2, 3); ir_i = w; pc_i = 32'h100;
    tick();
    nvec++; if (data1_o !== 32'd5) begin nerr++; $display("FAIL alu_d1 got %h want 5", data1_o); end
    nvec++; if (data2_o !== 32'd7) begin nerr++; $display("FAIL alu_d2 got %h want 7", data2_o); end
    nvec++; if (reg_write_o !== 2'b11) begin nerr++; $display("FAIL alu_rw got %b want 11", reg_write_o); end
    nvec++; if (ir_o !== w || pc_o !== 32'h100) begin nerr++; $display("FAIL alu_irpc got %h %h want %h 100", ir_o, pc_o, w); end
  endtask

  task automatic test_writethrough();
    ir_i = mk(T_ALU, 0, 0, 4, 0); pc_i = 32'h104;
    wb_wen = 2'b11; wb_addr = 4'd4; wb_data = 32'hdeadbeef;
    tick();
    wb_wen = 0;
    nvec++; if (data1_o !== 32'hdeadbeef) begin nerr++; $display("FAIL wt_d1 got %h want deadbeef", data1_o); end
    nvec++; if (data2_o !== 32'h0) begin nerr++; $display("FAIL wt_d2 got %h want 0", data2_o); end
    tick();
    nvec++; if (data1_o !== 32'hdeadbeef) begin nerr++; $display("FAIL wt_stored got %h want deadbeef", data1_o); end
  endtask

  task automatic test_lanes();
    ir_i = mk(T_ALU, 0, 0, 4, 4); pc_i = 32'h108;
    ex_wen = 2'b01; ex_addr = 4'd4; ex_data = 32'h0000_1234;
    wb_wen = 2'b11; wb_addr = 4'd4; wb_data = 32'haaaa_5555;
    tick();
    nvec++; if (data1_o !== 32'haaaa_1234) begin nerr++; $display("FAIL lane_mix got %h want aaaa1234", data1_o); end
    wb_wen = 0; ex_wen = 2'b10; ex_data = 32'hbeef_0000;
    tick();
    nvec++; if (data1_o !== 32'hbeef_5555 || data2_o !== 32'hbeef_5555) begin nerr++; $display("FAIL lane_ex_hi got %h %h want beef5555", data1_o, data2_o); end
    ex_wen = 2'b00; ex_data = 32'hffff_ffff;
    tick();
    nvec++; if (data1_o !== 32'haaaa_5555) begin nerr++; $display("FAIL lane_ex_off got %h want aaaa5555", data1_o); end
    wb_wen = 2'b01; wb_data = 32'h0000_7777;
    tick();
    wb_wen = 0;
    nvec++; if (data1_o !== 32'haaaa_7777) begin nerr++; $display("FAIL lane_wb_lo got %h want aaaa7777", data1_o); end
    tick();
    nvec++; if (data2_o !== 32'haaaa_7777) begin nerr++; $display("FAIL lane_wb_stored got %h want aaaa7777", data2_o); end
  endtask

  task automatic test_hazard();
    logic [63:0] w;
    ir_i = mk(T_LOAD, 0, 6, 0, 0); pc_i = 32'h200;
    tick();
    nvec++; if (reg_write_o !== 2'b11 || ir_o[31:28] !== T_LOAD) begin nerr++; $display("FAIL hz_load got %b %h want 11 b", reg_write_o, ir_o[31:28]); end
    w = mk(T_ALU, 0, 0, 6, 1); ir_i = w; pc_i = 32'h204;
    #1;
    nvec++; if (stall_o !== 1'b1) begin nerr++; $display("FAIL hz_src1 got %b want 1", stall_o); end
    tick();
    nvec++; if (ir_o !== 64'h0 || reg_write_o !== 2'b00 || pc_o !== 32'h204) begin nerr++; $display("FAIL hz_bubble got %h %b %h want 0 00 204", ir_o, reg_write_o, pc_o); end
    nvec++; if (stall_o !== 1'b0) begin nerr++; $display("FAIL hz_clear got %b want 0", stall_o); end
    tick();
    nvec++; if (ir_o !== w) begin nerr++; $display("FAIL hz_reissue got %h want %h", ir_o, w); end
    ir_i = mk(T_LOAD, 0, 6, 0, 0); pc_i = 32'h208;
    tick();
    ir_i = mk(T_ALU, 0, 0, 1, 6); pc_i = 32'h20c;
    #1;
    nvec++; if (stall_o !== 1'b1) begin nerr++; $display("FAIL hz_src2 got %b want 1", stall_o); end
    flush_i = 1;
    #1;
    nvec++; if (stall_o !== 1'b0) begin nerr++; $display("FAIL hz_flush_mask got %b want 0", stall_o); end
    tick();
    flush_i = 0;
    nvec++; if (ir_o !== 64'h0 || pc_o !== 32'h20c) begin nerr++; $display("FAIL hz_flush got %h %h want 0 20c", ir_o, pc_o); end
    ir_i = mk(T_LOAD, 0, 6, 0, 0); pc_i = 32'h210;
    tick();
    ir_i = mk(T_ALU, 0, 6, 2, 3); pc_i = 32'h214;
    #1;
    nvec++; if (stall_o !== 1'b0) begin nerr++; $display("FAIL hz_nomatch got %b want 0", stall_o); end
    ir_i = mk(T_CMP, 0, 6, 2, 3);
    #1;
    nvec++; if (stall_o !== 1'b1) begin nerr++; $display("FAIL hz_cmp_ra got %b want 1", stall_o); end
    ir_i = mk(T_ALU, 0, 6, 2, 3);
    tick();
    nvec++; if (data1_o !== 32'd5 || reg_write_o !== 2'b11) begin nerr++; $display("FAIL hz_pass got %h %b want 5 11", data1_o, reg_write_o); end
  endtask

  task automatic test_stall();
    logic [63:0] w;
    w = mk(T_ALU, 0, 0, 2, 3); ir_i = w; pc_i = 32'h300;
    tick();
    stall_i = 1; ir_i = mk(T_MOV, 1, 0, 1, 1); pc_i = 32'h304;
    wb_wen = 2'b11; wb_addr = 4'd5; wb_data = 32'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      wb_wen = 0;
      nvec++;
      if (ir_o !== w || pc_o !== 32'h300 || reg_write_o !== 2'b11 || data1_o !== 32'd5 || data2_o !== 32'd7) begin
        nerr++; $display("FAIL stall_hold%0d got %h %h %b %h %h want %h 300 11 5 7", i, ir_o, pc_o, reg_write_o, data1_o, data2_o, w);
      end
    end
    flush_i = 1;
    tick();
    nvec++; if (ir_o !== 64'h0 || reg_write_o !== 2'b00 || pc_o !== 32'h304 || data1_o !== 32'h0) begin nerr++; $display("FAIL stall_flush got %h %b %h %h want 0 00 304 0", ir_o, reg_write_o, pc_o, data1_o); end
    flush_i = 0; stall_i = 0;
    ir_i = mk(T_ALU, 0, 0, 5, 0); pc_i = 32'h308;
    tick();
    nvec++; if (data1_o !== 32'h55) begin nerr++; $display("FAIL stall_wb got %h want 55", data1_o); end
  endtask

  task automatic test_mov_cmp();
    wb_write(4'd1, 32'h11);
    ir_i = mk(T_MOV, 4'b0001, 0, 1, 2); pc_i = 32'h400;
    tick();
    nvec++; if (reg_write_o !== 2'b01 || data1_o !== 32'h11 || data2_o !== 32'd5) begin nerr++; $display("FAIL mov got %b %h %h want 01 11 5", reg_write_o, data1_o, data2_o); end
    ir_i = mk(T_CMP, 0, 1, 2, 9);
    tick();
    nvec++; if (reg_write_o !== 2'b00 || data1_o !== 32'h11 || data2_o !== 32'd5) begin nerr++; $display("FAIL cmp got %b %h %h want 00 11 5", reg_write_o, data1_o, data2_o); end
    ir_i = mk(T_STORE, 0, 2, 1, 9);
    tick();
    nvec++; if (reg_write_o !== 2'b00 || data1_o !== 32'd5 || data2_o !== 32'h11) begin nerr++; $display("FAIL store got %b %h %h want 00 5 11", reg_write_o, data1_o, data2_o); end
    ir_i = mk(T_LDI, 0, 2, 1, 9);
    tick();
    nvec++; if (reg_write_o !== 2'b11) begin nerr++; $display("FAIL ldi got %b want 11", reg_write_o); end
  endtask

  task automatic test_reset_hazard();
    ir_i = mk(T_LOAD, 0, 6, 0, 0); pc_i = 32'h500;
    tick();
    ir_i = mk(T_ALU, 0, 0, 6, 0);
    #1;
    nvec++; if (stall_o !== 1'b1) begin nerr++; $display("FAIL rh_pre got %b want 1", stall_o); end
    rst = 1;
    tick();
    rst = 0;
    nvec++; if (ir_o !== 64'h0 || stall_o !== 1'b0 || pc_o !== 32'h0) begin nerr++; $display("FAIL rh_reset got %h %b %h want 0 0 0", ir_o, stall_o, pc_o); end
    ir_i = mk(T_ALU, 0, 0, 2, 3);
    tick();
    nvec++; if (data1_o !== 32'h0 || data2_o !== 32'h0) begin nerr++; $display("FAIL rh_regs got %h %h want 0 0", data1_o, data2_o); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_writethrough();
    test_lanes();
    test_hazard();
    test_stall();
    test_mov_cmp();
    test_reset_hazard();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
